check_scoreboard: RTL and testbench
===================================

Name: check_scoreboard

Overview:
- Synthesizable multi-channel expected/actual checker for on-board self-test and Verilator benches.
- Compares N_CH channels per cycle under a bit mask and keeps saturating pass/fail counters.
- Logs each failure (channel, tag, expected, actual) into a drainable FIFO, so a UART dumper or bench can read the fail list after a run.

Parameters:
- DATA_W, 32, width of the compared values
- N_CH, 4, number of independent check channels
- TAG_W, 16, width of the per-check tag (line number or test id)
- LOG_DEPTH, 16, fail-log FIFO entries (power of 2, >=2)
- CNT_W, 32, width of the pass/fail/dropped counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear: counters, hold registers and FIFO
- chk_valid  in  N_CH  per-channel check strobe
- chk_tag  in  N_CH*TAG_W  per-channel tag, channel i at [i*TAG_W +: TAG_W]
- chk_expected  in  N_CH*DATA_W  expected values, packed the same way
- chk_actual  in  N_CH*DATA_W  actual values
- chk_mask  in  N_CH*DATA_W  compare enable per bit (1 = compared)
- pass_count  out  CNT_W  total passing checks
- fail_count  out  CNT_W  total failing checks
- drop_count  out  CNT_W  failures not logged
- any_fail  out  1  sticky, set on first failure
- log_valid  out  1  fail-log head entry available
- log_ready  in  1  consumer accepts head entry
- log_ch  out  $clog2(N_CH) (min 1)  channel of head entry
- log_tag  out  TAG_W  tag of head entry
- log_expected  out  DATA_W  expected value of head entry
- log_actual  out  DATA_W  actual value of head entry
- log_count  out  $clog2(LOG_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, async): all counters 0, any_fail 0, hold registers empty, FIFO empty, log_valid 0, log_* data 0, log_count 0.
- Compare rule:
  - Channel i fails iff ((expected ^ actual) & mask) != 0; otherwise it passes.
  - mask all-zero always passes.
- Counters:
  - At each edge, pass_count += popcount(valid & pass) and fail_count += popcount(valid & fail).
  - Updated values are visible the cycle after the strobe.
  - All counters saturate at 2^CNT_W-1; no wrap.
- any_fail: set at the same edge that fail_count first increments; cleared only by reset or clear.
- Hold stage (one register per channel):
  - A failing check loads {ch, tag, expected, actual} into hold[i] at the strobe edge.
  - If hold[i] is still occupied and not draining that same edge, the new failure is dropped and drop_count increments.
  - It is still counted in fail_count.
- Drain stage:
  - Each edge, the lowest-index occupied hold register pushes into the FIFO if the FIFO is not full.
  - That hold register frees at this edge and may reload at the same edge; drain and load in one cycle is not a drop.
  - One push per cycle maximum.
  - FIFO full: hold registers keep their contents (backpressure); drops occur only through the occupied-hold rule.
- Latency: a strobe at edge N gives the earliest log_valid after edge N+1 (hold, then push). Each additional simultaneous failure adds 1 cycle.
- FIFO read:
  - First-word-fall-through: log_* show the head entry whenever log_valid=1.
  - Pop on log_valid & log_ready.
  - Push and pop in the same cycle keep log_count unchanged; pop while full allows a push the same edge.
  - log_ready while empty has no effect.
  - Pointers wrap modulo LOG_DEPTH.
- clear: synchronous, has priority over all same-cycle strobes, which are discarded (not counted). Behaves as reset except that it is taken at the clock edge.
- Reset mid-operation: pending hold and FIFO contents are lost with no partial output; log_valid deasserts asynchronously.

Decomposition:
- check_pkg:
  - typedef fail_rec_t struct packed {ch, tag, expected, actual}, sized from package parameters that mirror the module defaults
  - function popcount
  - function sat_add (saturating add)
- Sub-module sync_fifo:
  - Parametrised WIDTH/DEPTH, FWFT, with valid/ready read, push/full write and count.
  - Reusable elsewhere (UART tx buffer).
- check_scoreboard instantiates one sync_fifo of fail_rec_t width.

Test Plan:
- Basic pass/fail:
  - Single channel: ch0 valid, expected=5, actual=5, mask=all-ones gives pass_count=1, fail_count=0, log_valid stays 0.
  - Then expected=5, actual=7 gives fail_count=1, any_fail=1, and two cycles later log entry {ch0, tag=42, 5, 7}.
- Mask: expected=0xFF00, actual=0xFF01, mask=0xFF00 -> pass. Same values with mask=0xFFFF -> fail.
- Simultaneous failures: all 4 channels fail in one cycle with tags 10..13 -> fail_count=4. FIFO pops in order ch0, ch1, ch2, ch3 on consecutive cycles with log_ready=1.
- Full FIFO, drops and order: LOG_DEPTH=4, log_ready=0, ch0 fails on 7 consecutive cycles with tags 1..7 -> fail_count=7, log_count=4, and tag 5 parked in hold[0]. Tags 6 and 7 are dropped, drop_count=2. Then raise log_ready: entries read out as 1, 2, 3, 4, 5.
- Saturation and clear:
  - CNT_W=4: 20 passes -> pass_count=15.
  - Pulse clear while ch1 strobes a failure -> all counters 0, any_fail 0, log_valid 0, and the strobe is not counted.
- Async reset: assert rst_n low mid-drain with 3 entries queued -> log_valid and counters go to 0 immediately with no clock edge. After release, a new failure logs normally.

Source files
------------

// File: rtl/check_pkg.sv
// Shared types and helpers for the expected/actual check scoreboard.
// The record type mirrors the default module configuration. A scoreboard
// built with other widths declares its own record of the same layout.
package check_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_N_CH   = 4;
    localparam int DEF_TAG_W  = 16;
    localparam int DEF_CH_W   = (DEF_N_CH > 1) ? $clog2(DEF_N_CH) : 1;

    // Widest vector the helpers accept (popcount input and counter width).
    localparam int MAX_W = 64;

    typedef struct packed {
        logic [DEF_CH_W-1:0]   ch;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_DATA_W-1:0] expected;
        logic [DEF_DATA_W-1:0] actual;
    } fail_rec_t;

    // Count the set bits of a strobe vector; callers zero-extend to 64 bits.
    function automatic logic [6:0] popcount(input logic [MAX_W-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

    // a + b clamped to 2^w - 1. w is the counter width, 1..64.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned     w);
        logic [MAX_W:0] sum;
        logic [MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        if (w >= MAX_W) begin
            lim = {1'b0, {MAX_W{1'b1}}};
        end else begin
            lim = ({{MAX_W{1'b0}}, 1'b1} << w) - {{MAX_W{1'b0}}, 1'b1};
        end
        return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Handshake: the read side presents pop_data whenever pop_valid=1 and an entry
// leaves on a rising edge where pop_valid & pop_ready; pop_data reads as zero
// while empty. The write side accepts push_data on an edge where push=1 and
// either the FIFO is not full or a pop happens on that same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Handshake decode; a pop frees a slot for a push on the same edge.
    always_comb begin
        pop_valid = (count != '0);
        full      = (count == CW'(DEPTH));
        do_pop    = pop_valid & pop_ready;
        do_push   = push & (~full | do_pop);
        pop_data  = pop_valid ? mem[rd_ptr] : '0;
    end

    // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because reads are gated by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/check_scoreboard.sv
// Multi-channel masked expected/actual checker with saturating pass/fail/drop
// counters and a drainable log of failures. Counters up to 64 bits wide.
// Failing checks land in a per-channel hold register, and the lowest occupied
// hold register moves into the fail-log FIFO one entry per cycle.
module check_scoreboard
    import check_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int N_CH      = 4,
    parameter int TAG_W     = 16,
    parameter int LOG_DEPTH = 16,
    parameter int CNT_W     = 32,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LC_W = $clog2(LOG_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [N_CH-1:0]        chk_valid,
    input  logic [N_CH*TAG_W-1:0]  chk_tag,
    input  logic [N_CH*DATA_W-1:0] chk_expected,
    input  logic [N_CH*DATA_W-1:0] chk_actual,
    input  logic [N_CH*DATA_W-1:0] chk_mask,
    output logic [CNT_W-1:0]       pass_count,
    output logic [CNT_W-1:0]       fail_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   any_fail,
    output logic                   log_valid,
    input  logic                   log_ready,
    output logic [CH_W-1:0]        log_ch,
    output logic [TAG_W-1:0]       log_tag,
    output logic [DATA_W-1:0]      log_expected,
    output logic [DATA_W-1:0]      log_actual,
    output logic [LC_W-1:0]        log_count
);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] expected;
        logic [DATA_W-1:0] actual;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    logic [N_CH-1:0] fail_hit;
    logic [N_CH-1:0] pass_stb;
    logic [N_CH-1:0] fail_stb;
    logic [N_CH-1:0] hold_vld;
    rec_t            hold_rec [N_CH];
    logic [N_CH-1:0] drain_sel;
    logic [N_CH-1:0] load_en;
    logic [N_CH-1:0] drop_en;
    logic            fifo_full;
    logic            drain_en;
    rec_t            push_rec;
    rec_t            head_rec;
    logic [REC_W-1:0] head_bits;

    // Masked compare per channel; an all-zero mask can never flag a difference.
    always_comb begin
        fail_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            fail_hit[i] = |((chk_expected[i*DATA_W +: DATA_W] ^
                             chk_actual[i*DATA_W +: DATA_W]) &
                            chk_mask[i*DATA_W +: DATA_W]);
        end
        pass_stb = chk_valid & ~fail_hit;
        fail_stb = chk_valid & fail_hit;
    end

    // Pick the lowest occupied hold register for the FIFO; a same-edge pop
    // makes room even when the FIFO is full.
    always_comb begin
        drain_en  = (|hold_vld) & (~fifo_full | (log_valid & log_ready));
        drain_sel = drain_en ? (hold_vld & (~hold_vld + N_CH'(1))) : '0;
        push_rec  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (drain_sel[i]) push_rec = hold_rec[i];
        end
        // A hold register that drains this edge can take a new failure.
        load_en = fail_stb & (~hold_vld | drain_sel);
        drop_en = fail_stb & hold_vld & ~drain_sel;
    end

    // Hold registers: load on failure, free when pushed into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld <= '0;
            for (int i = 0; i < N_CH; i++) hold_rec[i] <= '0;
        end else if (clear) begin
            hold_vld <= '0;
            for (int i = 0; i < N_CH; i++) hold_rec[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (load_en[i]) begin
                    hold_vld[i] <= 1'b1;
                    hold_rec[i] <= '{ch:       CH_W'(i),
                                     tag:      chk_tag[i*TAG_W +: TAG_W],
                                     expected: chk_expected[i*DATA_W +: DATA_W],
                                     actual:   chk_actual[i*DATA_W +: DATA_W]};
                end else if (drain_sel[i]) begin
                    hold_vld[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating counters and the sticky failure flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count <= '0;
            fail_count <= '0;
            drop_count <= '0;
            any_fail   <= 1'b0;
        end else if (clear) begin
            pass_count <= '0;
            fail_count <= '0;
            drop_count <= '0;
            any_fail   <= 1'b0;
        end else begin
            pass_count <= CNT_W'(sat_add(MAX_W'(pass_count),
                                         MAX_W'(popcount(MAX_W'(pass_stb))), CNT_W));
            fail_count <= CNT_W'(sat_add(MAX_W'(fail_count),
                                         MAX_W'(popcount(MAX_W'(fail_stb))), CNT_W));
            drop_count <= CNT_W'(sat_add(MAX_W'(drop_count),
                                         MAX_W'(popcount(MAX_W'(drop_en))), CNT_W));
            if (|fail_stb) any_fail <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (drain_en),
        .push_data (push_rec),
        .full      (fifo_full),
        .pop_valid (log_valid),
        .pop_ready (log_ready),
        .pop_data  (head_bits),
        .count     (log_count)
    );

    // Unpack the head entry; the FIFO already zeroes it while empty.
    always_comb begin
        head_rec     = rec_t'(head_bits);
        log_ch       = head_rec.ch;
        log_tag      = head_rec.tag;
        log_expected = head_rec.expected;
        log_actual   = head_rec.actual;
    end

endmodule

// File: tb/tb_check_scoreboard.sv
// Bench for check_scoreboard: small FIFO and 4-bit counters so the full-log,
// drop and saturation paths are reachable in a few cycles.
module tb_check_scoreboard;

    localparam int DATA_W    = 32;
    localparam int N_CH      = 4;
    localparam int TAG_W     = 16;
    localparam int LOG_DEPTH = 4;
    localparam int CNT_W     = 4;
    localparam int CH_W      = 2;
    localparam int LC_W      = 3;
    localparam int REC_W     = CH_W + TAG_W + 2 * DATA_W;

    logic                   clk;
    logic                   rst_n;
    logic                   clear;
    logic [N_CH-1:0]        chk_valid;
    logic [N_CH*TAG_W-1:0]  chk_tag;
    logic [N_CH*DATA_W-1:0] chk_expected;
    logic [N_CH*DATA_W-1:0] chk_actual;
    logic [N_CH*DATA_W-1:0] chk_mask;
    logic [CNT_W-1:0]       pass_count;
    logic [CNT_W-1:0]       fail_count;
    logic [CNT_W-1:0]       drop_count;
    logic                   any_fail;
    logic                   log_valid;
    logic                   log_ready;
    logic [CH_W-1:0]        log_ch;
    logic [TAG_W-1:0]       log_tag;
    logic [DATA_W-1:0]      log_expected;
    logic [DATA_W-1:0]      log_actual;
    logic [LC_W-1:0]        log_count;

    logic [REC_W-1:0] exp_q[$];
    int n_checks;
    int n_errors;

    check_scoreboard #(
        .DATA_W    (DATA_W),
        .N_CH      (N_CH),
        .TAG_W     (TAG_W),
        .LOG_DEPTH (LOG_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .chk_valid    (chk_valid),
        .chk_tag      (chk_tag),
        .chk_expected (chk_expected),
        .chk_actual   (chk_actual),
        .chk_mask     (chk_mask),
        .pass_count   (pass_count),
        .fail_count   (fail_count),
        .drop_count   (drop_count),
        .any_fail     (any_fail),
        .log_valid    (log_valid),
        .log_ready    (log_ready),
        .log_ch       (log_ch),
        .log_tag      (log_tag),
        .log_expected (log_expected),
        .log_actual   (log_actual),
        .log_count    (log_count)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Checking
    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Log monitor: compare each popped entry against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n && !clear && log_valid && log_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_log", 128'(1), 128'(0));
            end else begin
                check_val("log_entry",
                          128'({log_ch, log_tag, log_expected, log_actual}),
                          128'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chk_valid    = '0;
        chk_tag      = '0;
        chk_expected = '0;
        chk_actual   = '0;
        chk_mask     = '0;
    endtask

    task automatic set_ch(input int ch, input logic [TAG_W-1:0] tag,
                          input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] m);
        chk_valid[ch]                   = 1'b1;
        chk_tag[ch*TAG_W +: TAG_W]      = tag;
        chk_expected[ch*DATA_W +: DATA_W] = e;
        chk_actual[ch*DATA_W +: DATA_W]   = a;
        chk_mask[ch*DATA_W +: DATA_W]     = m;
    endtask

    task automatic expect_log(input int ch, input logic [TAG_W-1:0] tag,
                              input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] a);
        exp_q.push_back({CH_W'(ch), tag, e, a});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        check_val("drain_left", 128'(exp_q.size()), 128'(0));
    endtask

    // Stimulus
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        log_ready = 1'b0;
        idle();
        repeat (3) tick();

        check_val("rst_pass",  128'(pass_count), 128'(0));
        check_val("rst_fail",  128'(fail_count), 128'(0));
        check_val("rst_drop",  128'(drop_count), 128'(0));
        check_val("rst_any",   128'(any_fail),   128'(0));
        check_val("rst_valid", 128'(log_valid),  128'(0));
        check_val("rst_count", 128'(log_count),  128'(0));
        check_val("rst_tag",   128'(log_tag),    128'(0));
        rst_n = 1'b1;
        tick();

        // Basic pass then fail on channel 0
        log_ready = 1'b1;
        set_ch(0, 16'd42, 32'd5, 32'd5, '1);
        tick();
        idle();
        check_val("basic_pass", 128'(pass_count), 128'(1));
        check_val("basic_fail0", 128'(fail_count), 128'(0));
        check_val("basic_nolog", 128'(log_valid), 128'(0));
        set_ch(0, 16'd42, 32'd5, 32'd7, '1);
        expect_log(0, 16'd42, 32'd5, 32'd7);
        tick();
        idle();
        check_val("basic_fail1", 128'(fail_count), 128'(1));
        check_val("basic_any", 128'(any_fail), 128'(1));
        check_val("basic_hold_latency", 128'(log_valid), 128'(0));
        tick();
        check_val("basic_log_valid", 128'(log_valid), 128'(1));
        wait_drain(5);

        // Mask handling
        set_ch(0, 16'd1, 32'h0000_FF00, 32'h0000_FF01, 32'h0000_FF00);
        tick();
        idle();
        check_val("mask_pass", 128'(pass_count), 128'(2));
        set_ch(0, 16'd2, 32'h0000_FF00, 32'h0000_FF01, 32'h0000_FFFF);
        expect_log(0, 16'd2, 32'h0000_FF00, 32'h0000_FF01);
        tick();
        idle();
        check_val("mask_fail", 128'(fail_count), 128'(2));
        set_ch(1, 16'd3, $urandom, $urandom, '0);
        tick();
        idle();
        check_val("mask_zero_pass", 128'(pass_count), 128'(3));
        wait_drain(5);

        // Four simultaneous failures drain in channel order
        for (int i = 0; i < N_CH; i++) begin
            logic [DATA_W-1:0] e;
            e = DATA_W'($urandom_range(0, 1000));
            set_ch(i, TAG_W'(10 + i), e, e ^ 32'h8000_0001, '1);
            expect_log(i, TAG_W'(10 + i), e, e ^ 32'h8000_0001);
        end
        tick();
        idle();
        check_val("multi_fail", 128'(fail_count), 128'(6));
        wait_drain(10);
        check_val("multi_drop", 128'(drop_count), 128'(0));
        do_clear();

        // Full FIFO, backpressure into hold, and drops
        log_ready = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            set_ch(0, TAG_W'(t), DATA_W'(t), ~DATA_W'(t), '1);
            if (t <= 5) expect_log(0, TAG_W'(t), DATA_W'(t), ~DATA_W'(t));
            tick();
        end
        idle();
        check_val("full_fail", 128'(fail_count), 128'(7));
        check_val("full_drop", 128'(drop_count), 128'(2));
        check_val("full_count", 128'(log_count), 128'(LOG_DEPTH));
        check_val("full_head_tag", 128'(log_tag), 128'(1));
        log_ready = 1'b1;
        wait_drain(20);
        tick();
        check_val("full_empty", 128'(log_count), 128'(0));
        check_val("full_drop_kept", 128'(drop_count), 128'(2));
        do_clear();

        // Counter saturation
        for (int t = 0; t < 20; t++) begin
            set_ch(0, TAG_W'(t), DATA_W'(t), DATA_W'(t), '1);
            tick();
        end
        idle();
        check_val("sat_pass", 128'(pass_count), 128'(15));
        check_val("sat_fail", 128'(fail_count), 128'(0));

        // Clear beats a same-cycle failing strobe
        set_ch(0, 16'd7, 32'd1, 32'd1, '1);
        tick();
        idle();
        set_ch(1, 16'd77, 32'd1, 32'd2, '1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle();
        check_val("clr_pass", 128'(pass_count), 128'(0));
        check_val("clr_fail", 128'(fail_count), 128'(0));
        check_val("clr_any", 128'(any_fail), 128'(0));
        check_val("clr_valid", 128'(log_valid), 128'(0));
        repeat (3) tick();
        check_val("clr_no_log", 128'(log_count), 128'(0));

        // Asynchronous reset with entries queued
        log_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_ch(i, TAG_W'(20 + i), 32'd0, 32'd1, '1);
        tick();
        idle();
        repeat (3) tick();
        check_val("pre_rst_count", 128'(log_count), 128'(3));
        check_val("pre_rst_fail", 128'(fail_count), 128'(3));
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", 128'(log_valid), 128'(0));
        check_val("arst_count", 128'(log_count), 128'(0));
        check_val("arst_fail", 128'(fail_count), 128'(0));
        check_val("arst_any", 128'(any_fail), 128'(0));
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        log_ready = 1'b1;
        set_ch(3, 16'd99, 32'hDEAD_BEEF, 32'hDEAD_BEEE, '1);
        expect_log(3, 16'd99, 32'hDEAD_BEEF, 32'hDEAD_BEEE);
        tick();
        idle();
        check_val("post_rst_fail", 128'(fail_count), 128'(1));
        wait_drain(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
